// File: rtl/pipelined_left_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_left_shifter
// Brief    : Five-stage logical left shifter (16/8/4/2/1) with valid/ready
//            handshake, global stall and shifted-out-ones indication.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_left_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_lost
);

    localparam int              c_NUM_STAGES = SHAMT_W;
    localparam logic [WIDTH-1:0] c_ONES      = '1;

    logic                      w_advance;
    logic [c_NUM_STAGES-1:0]   r_valid;
    logic [c_NUM_STAGES-1:0]   r_lost;
    logic [WIDTH-1:0]          r_data [0:c_NUM_STAGES-1];
    // Stage k only consumes amount bit (SHAMT_W-1-k); the last stage reads
    // its bit from the register feeding it, so no amount register follows it.
    logic [SHAMT_W-1:0]        r_amt  [0:c_NUM_STAGES-2];

    logic [c_NUM_STAGES-1:0]   w_src_valid;
    logic [c_NUM_STAGES-1:0]   w_src_lost;
    logic [c_NUM_STAGES-1:0]   w_sel;
    logic [c_NUM_STAGES-1:0]   w_nxt_lost;
    logic [WIDTH-1:0]          w_src_data [0:c_NUM_STAGES-1];
    logic [WIDTH-1:0]          w_nxt_data [0:c_NUM_STAGES-1];

    assign w_advance = out_ready | ~r_valid[c_NUM_STAGES-1];
    assign in_ready  = w_advance;

    genvar k;
    generate
        for (k = 0; k < c_NUM_STAGES; k++) begin : g_stage
            localparam int c_SHIFT = 1 << (SHAMT_W - 1 - k);

            if (k == 0) begin : g_head
                assign w_src_valid[k] = in_valid;
                assign w_src_data[k]  = data_operandA;
                assign w_src_lost[k]  = 1'b0;
                assign w_sel[k]       = ctrl_shiftamt[SHAMT_W-1];
            end else begin : g_body
                assign w_src_valid[k] = r_valid[k-1];
                assign w_src_data[k]  = r_data[k-1];
                assign w_src_lost[k]  = r_lost[k-1];
                assign w_sel[k]       = r_amt[k-1][SHAMT_W-1-k];
            end

            // Ones in the top c_SHIFT bits fall off the word when this stage shifts.
            assign w_nxt_data[k] = w_sel[k] ? (w_src_data[k] << c_SHIFT) : w_src_data[k];
            assign w_nxt_lost[k] = w_src_lost[k]
                                 | (w_sel[k] & (|(w_src_data[k] & ~(c_ONES >> c_SHIFT))));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_lost  <= '0;
            for (int i = 0; i < c_NUM_STAGES; i++) begin
                r_data[i] <= '0;
            end
            for (int i = 0; i < c_NUM_STAGES - 1; i++) begin
                r_amt[i] <= '0;
            end
        end else if (w_advance) begin
            r_valid <= w_src_valid;
            r_lost  <= w_nxt_lost;
            for (int i = 0; i < c_NUM_STAGES; i++) begin
                r_data[i] <= w_nxt_data[i];
            end
            r_amt[0] <= ctrl_shiftamt;
            for (int i = 1; i < c_NUM_STAGES - 1; i++) begin
                r_amt[i] <= r_amt[i-1];
            end
        end
    end

    assign out_valid   = r_valid[c_NUM_STAGES-1];
    assign data_result = r_data[c_NUM_STAGES-1];
    assign data_lost   = r_lost[c_NUM_STAGES-1];

endmodule
`default_nettype wire
